md5_core_arbiter: RTL and testbench

Round-robin scheduler that shares one MD5 core (pancham interface) between NUM_REQ brute-force candidate generators, each searching its own slice of the keyspace.
- Accepts one word at a time from the requesters, issues it to the core, and holds the issue until the core accepts it.
- Waits for the digest and returns it, tagged with the requester index, to the downstream comparator stage.
- Sits between the BruteForce instances and the single shared hasher in the cracking top level.

---
 rtl/md5_core_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_md5_core_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_core_arbiter.sv
// md5_core_arbiter
// Round-robin scheduler that shares one MD5 core between NUM_REQ
// candidate generators. One job is in flight at a time:
//   IDLE  -> grant the next requester, latch its word and length
//   ISSUE -> hold core_valid until the core accepts the word
//   WAIT  -> return the digest tagged with the requester index,
//            or give up after TIMEOUT cycles
// Ports:
//   clock, reset (async, active-low), halt (blocks new grants only)
//   req_valid/req_word/req_width/req_ready : requester side (flat vectors)
//   core_word/core_width/core_valid/core_ready,
//   core_hash/core_hash_valid              : shared MD5 core
//   rsp_valid/rsp_tag/rsp_word/rsp_hash/rsp_timeout : comparator side
//   busy                                   : state is not IDLE
// All outputs are registered.
module md5_core_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 2,
   parameter int WORD_W  = 128,
   parameter int WIDTH_W = 8,
   parameter int HASH_W  = 128,
   parameter int TIMEOUT = 255
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         halt,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*WORD_W-1:0]    req_word,
   input  logic [NUM_REQ*WIDTH_W-1:0]   req_width,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [WORD_W-1:0]            core_word,
   output logic [WIDTH_W-1:0]           core_width,
   output logic                         core_valid,
   input  logic                         core_ready,
   input  logic [HASH_W-1:0]            core_hash,
   input  logic                         core_hash_valid,
   output logic                         rsp_valid,
   output logic [TAG_W-1:0]             rsp_tag,
   output logic [WORD_W-1:0]            rsp_word,
   output logic [HASH_W-1:0]            rsp_hash,
   output logic                         rsp_timeout,
   output logic                         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Extra bit so pointer+offset never overflows before the wrap.
   localparam logic [TAG_W:0] NUM_REQ_EXT = (TAG_W+1)'(NUM_REQ);
   // The timer counts completed WAIT cycles; the job is abandoned on the
   // edge where it would reach TIMEOUT.
   localparam logic [15:0]    TIMER_LAST  = 16'(TIMEOUT - 1);

   state_t               state;
   state_t               state_next;
   logic [TAG_W-1:0]     ptr;
   logic [TAG_W-1:0]     ptr_next;
   logic [TAG_W-1:0]     job_tag;
   logic [15:0]          timer;

   logic                 grant_found;
   logic [TAG_W-1:0]     grant_idx;
   logic [TAG_W:0]       cand;
   logic [TAG_W:0]       inc;
   logic                 hit;
   logic [NUM_REQ-1:0]   grant_onehot;
   logic [WORD_W-1:0]    sel_word;
   logic [WIDTH_W-1:0]   sel_width;

   logic                 do_grant;
   logic                 do_accept;
   logic                 do_hash;
   logic                 do_timeout;
   logic                 do_tick;

   // Round-robin search: first pending requester at or after ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      hit         = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand        = {1'b0, ptr} + (TAG_W+1)'(k);
         cand        = (cand >= NUM_REQ_EXT) ? (cand - NUM_REQ_EXT) : cand;
         hit         = req_valid[cand[TAG_W-1:0]] & ~grant_found;
         grant_idx   = hit ? cand[TAG_W-1:0] : grant_idx;
         grant_found = grant_found | hit;
      end
      inc          = {1'b0, grant_idx} + {{TAG_W{1'b0}}, 1'b1};
      inc          = (inc >= NUM_REQ_EXT) ? (inc - NUM_REQ_EXT) : inc;
      ptr_next     = inc[TAG_W-1:0];
      grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
   end

   // Word/length multiplexer for the granted requester.
   always_comb begin
      sel_word  = '0;
      sel_width = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_word  = (grant_idx == TAG_W'(i)) ? req_word[i*WORD_W +: WORD_W]    : sel_word;
         sel_width = (grant_idx == TAG_W'(i)) ? req_width[i*WIDTH_W +: WIDTH_W] : sel_width;
      end
   end

   // Next-state logic and per-edge action strobes.
   always_comb begin
      state_next = state;
      do_grant   = 1'b0;
      do_accept  = 1'b0;
      do_hash    = 1'b0;
      do_timeout = 1'b0;
      do_tick    = 1'b0;
      case (state)
         IDLE: begin
            if (!halt && grant_found) begin
               do_grant   = 1'b1;
               state_next = ISSUE;
            end else begin
               state_next = IDLE;
            end
         end
         ISSUE: begin
            if (core_ready) begin
               do_accept  = 1'b1;
               state_next = WAIT;
            end else begin
               state_next = ISSUE;
            end
         end
         WAIT: begin
            // A digest arriving on the expiry edge still wins.
            if (core_hash_valid) begin
               do_hash    = 1'b1;
               state_next = IDLE;
            end else if (timer == TIMER_LAST) begin
               do_timeout = 1'b1;
               state_next = IDLE;
            end else begin
               do_tick    = 1'b1;
               state_next = WAIT;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr         <= '0;
         job_tag     <= '0;
         timer       <= 16'd0;
         req_ready   <= '0;
         core_word   <= '0;
         core_width  <= '0;
         core_valid  <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_tag     <= '0;
         rsp_word    <= '0;
         rsp_hash    <= '0;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         req_ready   <= '0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         busy        <= (state_next != IDLE);
         if (do_grant) begin
            req_ready  <= grant_onehot;
            core_word  <= sel_word;
            core_width <= sel_width;
            rsp_word   <= sel_word;
            job_tag    <= grant_idx;
            ptr        <= ptr_next;
            core_valid <= 1'b1;
         end
         if (do_accept) begin
            core_valid <= 1'b0;
            timer      <= 16'd0;
         end
         if (do_tick) begin
            timer <= timer + 16'd1;
         end
         if (do_hash) begin
            rsp_valid <= 1'b1;
            rsp_hash  <= core_hash;
            rsp_tag   <= job_tag;
         end
         if (do_timeout) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_hash    <= '0;
            rsp_tag     <= job_tag;
         end
      end
   end

endmodule

// File: tb/tb_md5_core_arbiter.sv
// Testbench for md5_core_arbiter: requester and MD5-core models driven on
// the falling edge, scoreboard queues for expected grants and responses.
module tb_md5_core_arbiter;

   localparam int NR = 4;
   localparam int TW = 2;
   localparam int WW = 128;
   localparam int LW = 8;
   localparam int HW = 128;
   localparam int TO = 12;

   logic              clock = 1'b0;
   logic              reset;
   logic              halt;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*WW-1:0]  req_word = '0;
   logic [NR*LW-1:0]  req_width = '0;
   logic [NR-1:0]     req_ready;
   logic [WW-1:0]     core_word;
   logic [LW-1:0]     core_width;
   logic              core_valid;
   logic              core_ready = 1'b1;
   logic [HW-1:0]     core_hash = '0;
   logic              core_hash_valid = 1'b0;
   logic              rsp_valid;
   logic [TW-1:0]     rsp_tag;
   logic [WW-1:0]     rsp_word;
   logic [HW-1:0]     rsp_hash;
   logic              rsp_timeout;
   logic              busy;

   md5_core_arbiter #(
      .NUM_REQ(NR), .TAG_W(TW), .WORD_W(WW), .WIDTH_W(LW), .HASH_W(HW), .TIMEOUT(TO)
   ) dut (
      .clock(clock), .reset(reset), .halt(halt),
      .req_valid(req_valid), .req_word(req_word), .req_width(req_width),
      .req_ready(req_ready),
      .core_word(core_word), .core_width(core_width), .core_valid(core_valid),
      .core_ready(core_ready), .core_hash(core_hash), .core_hash_valid(core_hash_valid),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_word(rsp_word),
      .rsp_hash(rsp_hash), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int             tag;
      logic [WW-1:0]  word;
      logic [LW-1:0]  width;
      int             issue_len;
   } gnt_t;

   typedef struct {
      int             tag;
      logic [WW-1:0]  word;
      logic [HW-1:0]  hash;
      logic           timeout;
      int             lat;
   } rsp_t;

   gnt_t gnt_q[$];
   rsp_t rsp_q[$];

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int rsp_cnt = 0;
   int grant_cnt = 0;
   int entries = 0;
   int target[NR] = '{0, 0, 0, 0};
   int granted[NR] = '{0, 0, 0, 0};
   int hash_delay = 0;
   int stall_cfg = 0;
   int stall_left = 0;
   int stale_cnt = 0;
   int stale_done = 0;
   int grant_cyc = 0;
   int entry_cyc = 0;
   int wcnt = 0;
   bit active = 1'b0;
   bit cv_prev = 1'b0;
   logic [WW-1:0] cv_word = '0;
   gnt_t cur_g;

   function automatic logic [WW-1:0] make_word(input int i, input int s);
      if (i == 0 && s == 0) return {104'h0, 24'h616263};   // "abc"
      return {32'hCAFE0000, 32'(i), 32'(s), 32'h5A5A5A5A};
   endfunction

   function automatic logic [LW-1:0] make_width(input int i, input int s);
      if (i == 0 && s == 0) return 8'd3;
      return 8'(16 + i + s);
   endfunction

   // Stand-in digest function of the core model.
   function automatic logic [HW-1:0] make_hash(input logic [WW-1:0] w);
      return {w[63:0], w[127:64]} ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic push_gnt(input int tag, input int seq, input int len);
      gnt_t e;
      e.tag = tag; e.word = make_word(tag, seq); e.width = make_width(tag, seq);
      e.issue_len = len;
      gnt_q.push_back(e);
   endtask

   task automatic push_rsp(input int tag, input int seq, input bit to, input int lat);
      rsp_t r;
      r.tag = tag; r.word = make_word(tag, seq);
      r.hash = to ? '0 : make_hash(make_word(tag, seq));
      r.timeout = to; r.lat = lat;
      rsp_q.push_back(r);
   endtask

   task automatic wait_rsp(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && rsp_cnt < n; k++) @(posedge clock);
      #1;
      check(tag, 128'(rsp_cnt), 128'(n));
   endtask

   task automatic wait_entry(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && entries < n; k++) @(posedge clock);
      #1;
      check(tag, 128'(entries), 128'(n));
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_req_ready"}, 128'(req_ready), 128'(0));
      check({pfx, "_core_valid"}, 128'(core_valid), 128'(0));
      check({pfx, "_core_word"}, core_word, 128'(0));
      check({pfx, "_core_width"}, 128'(core_width), 128'(0));
      check({pfx, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
      check({pfx, "_rsp_timeout"}, 128'(rsp_timeout), 128'(0));
      check({pfx, "_rsp_tag"}, 128'(rsp_tag), 128'(0));
      check({pfx, "_rsp_word"}, rsp_word, 128'(0));
      check({pfx, "_rsp_hash"}, rsp_hash, 128'(0));
      check({pfx, "_busy"}, 128'(busy), 128'(0));
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Falling-edge process: monitor, requester model and core model.
   always @(negedge clock) begin
      // Grant monitor
      if (req_ready != '0) begin
         grant_cnt++;
         if (gnt_q.size() == 0) begin
            check("unexpected_grant", 128'(req_ready), 128'(0));
         end else begin
            cur_g = gnt_q.pop_front();
            check("grant_onehot", 128'(req_ready), 128'(4'b0001 << cur_g.tag));
            check("busy_at_grant", 128'(busy), 128'(1));
            grant_cyc  = cyc;
            stall_left = stall_cfg;
         end
      end
      // Issue monitor: word/length stable while core_valid is high
      if (core_valid) begin
         check("core_word", core_word, cur_g.word);
         check("core_width", 128'(core_width), 128'(cur_g.width));
         cv_word = core_word;
      end
      if (cv_prev && !core_valid && reset) begin
         check("issue_len", 128'(cyc - grant_cyc), 128'(cur_g.issue_len));
         entry_cyc = cyc;
         entries++;
         active = 1'b1;
         wcnt = 0;
      end
      // Response monitor
      if (rsp_valid) begin
         rsp_cnt++;
         active = 1'b0;
         if (rsp_q.size() == 0) begin
            check("unexpected_rsp", 128'(rsp_valid), 128'(0));
         end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            check("rsp_tag", 128'(rsp_tag), 128'(r.tag));
            check("rsp_word", rsp_word, r.word);
            check("rsp_hash", rsp_hash, r.hash);
            check("rsp_timeout", 128'(rsp_timeout), 128'(r.timeout));
            check("rsp_latency", 128'(cyc - entry_cyc), 128'(r.lat));
            check("busy_at_rsp", 128'(busy), 128'(0));
         end
      end
      // Requester model: advance on req_ready, valid while jobs remain
      for (int i = 0; i < NR; i++) begin
         if (req_ready[i]) granted[i]++;
         req_valid[i] = (granted[i] < target[i]);
         req_word[i*WW +: WW]  = make_word(i, granted[i]);
         req_width[i*LW +: LW] = make_width(i, granted[i]);
      end
      // Core model
      core_hash_valid = 1'b0;
      if (!reset) active = 1'b0;
      if (active) begin
         wcnt++;
         if (wcnt == hash_delay) begin
            core_hash_valid = 1'b1;
            core_hash = make_hash(cv_word);
            active = 1'b0;
         end
      end
      if (stale_done != stale_cnt) begin
         core_hash_valid = 1'b1;
         core_hash = '1;
         stale_done++;
      end
      if (core_valid && stall_left > 0) begin
         core_ready = 1'b0;
         stall_left--;
      end else begin
         core_ready = 1'b1;
      end
      cv_prev = core_valid;
   end

   initial begin
      reset = 1'b0;
      halt  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("por");
      reset = 1'b1;

      // Single requester, "abc"/3, digest 10 cycles into WAIT
      hash_delay = 10; stall_cfg = 0;
      push_gnt(0, 0, 1); push_rsp(0, 0, 1'b0, 10);
      target[0] = 1;
      wait_rsp("single_done", 1, 100);

      // Backpressure: core_ready low for 5 cycles after grant
      hash_delay = 3; stall_cfg = 5;
      push_gnt(1, 0, 6); push_rsp(1, 0, 1'b0, 3);
      target[1] = 1;
      wait_rsp("backpressure_done", 2, 100);

      // Timeout on two queued jobs; second grant follows the first abandon
      hash_delay = 0; stall_cfg = 0;
      push_gnt(2, 0, 1); push_rsp(2, 0, 1'b1, TO);
      push_gnt(3, 0, 1); push_rsp(3, 0, 1'b1, TO);
      target[2] = 1; target[3] = 1;
      wait_rsp("timeout_done", 4, 200);

      // Fairness: all requesters pending, pointer at 0
      hash_delay = 2;
      push_gnt(0, 1, 1); push_rsp(0, 1, 1'b0, 2);
      push_gnt(1, 1, 1); push_rsp(1, 1, 1'b0, 2);
      push_gnt(2, 1, 1); push_rsp(2, 1, 1'b0, 2);
      push_gnt(3, 1, 1); push_rsp(3, 1, 1'b0, 2);
      push_gnt(0, 2, 1); push_rsp(0, 2, 1'b0, 2);
      push_gnt(1, 2, 1); push_rsp(1, 2, 1'b0, 2);
      target[0] = 3; target[1] = 3; target[2] = 2; target[3] = 2;
      wait_rsp("fairness_done", 10, 300);

      // Digest on the expiry edge wins over the timeout
      hash_delay = TO;
      push_gnt(2, 2, 1); push_rsp(2, 2, 1'b0, TO);
      target[2] = 3;
      wait_rsp("simultaneous_done", 11, 100);

      // Halt during WAIT, then a stale digest while idle
      hash_delay = 8;
      push_gnt(3, 2, 1); push_rsp(3, 2, 1'b0, 8);
      target[3] = 3;
      wait_entry("halt_wait_entry", entries + 1, 100);
      @(posedge clock); #1;
      halt = 1'b1;
      target[0] = 4;
      wait_rsp("halt_rsp_delivered", 12, 100);
      repeat (10) @(posedge clock);
      stale_cnt++;
      repeat (5) @(posedge clock);
      #1;
      check("stale_ignored", 128'(rsp_cnt), 128'(12));
      check("halt_no_grant", 128'(grant_cnt), 128'(12));
      check("halt_idle", 128'(busy), 128'(0));
      push_gnt(0, 3, 1); push_rsp(0, 3, 1'b0, 8);
      halt = 1'b0;
      wait_rsp("halt_release_done", 13, 100);

      // Reset during WAIT; pointer returns to 0
      hash_delay = 0;
      push_gnt(1, 3, 1);
      target[1] = 4;
      wait_entry("reset_wait_entry", entries + 1, 100);
      target[0] = 5; target[2] = 4;
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check_reset_outputs("midjob");
      hash_delay = 4;
      push_gnt(0, 4, 1); push_rsp(0, 4, 1'b0, 4);
      push_gnt(2, 3, 1); push_rsp(2, 3, 1'b0, 4);
      @(posedge clock); #1;
      reset = 1'b1;
      wait_rsp("after_reset_done", 15, 200);

      repeat (5) @(posedge clock);
      #1;
      check("gnt_queue_empty", 128'(gnt_q.size()), 128'(0));
      check("rsp_queue_empty", 128'(rsp_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
